alu_pipe: RTL

//  Parametrised successor to the 8-bit enable-mode ALU. Two-stage pipeline with

---
 rtl/alu_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready bitwise ALU. It keeps the A/B op tables and the {a_en,b_en,alu_en} modes.
// It flags illegal modes, raises a sticky match irq and counts error-free results.
module alu_pipe #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] IRQ_VAL = '1,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        mode_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              out_err_o,
    output logic              irq_o,
    input  logic              irq_clr_i,
    output logic [CNT_W-1:0]  op_count_o
);
    localparam logic [2:0] MODE_A = 3'b101;
    localparam logic [2:0] MODE_B = 3'b011;

    logic              s1_valid_q;
    logic [2:0]        s1_mode_q;
    logic [1:0]        s1_op_q;
    logic [DATA_W-1:0] s1_a_q, s1_b_q;
    logic              s2_valid_q, s2_err_q;
    logic [DATA_W-1:0] s2_res_q;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_res_d;
    logic              alu_err_d;
    logic              s1_adv, s2_adv, accept, good_hs;

    assign s2_adv  = !s2_valid_q || out_ready_i;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign accept  = in_valid_i && s1_adv;
    assign good_hs = s2_valid_q && out_ready_i && !s2_err_q;

    always_comb begin
        alu_res_d = '0;
        alu_err_d = 1'b0;
        case (s1_mode_q)
            MODE_A: begin
                case (s1_op_q)
                    2'b00:   alu_res_d = s1_a_q & s1_b_q;
                    2'b01:   alu_res_d = ~(s1_a_q & s1_b_q);
                    2'b10:   alu_res_d = s1_a_q | s1_b_q;
                    default: alu_res_d = s1_a_q ^ s1_b_q;
                endcase
            end
            MODE_B: begin
                case (s1_op_q)
                    2'b00:   alu_res_d = ~(s1_a_q ^ s1_b_q);
                    2'b01:   alu_res_d = s1_a_q & s1_b_q;
                    2'b10:   alu_res_d = ~(s1_a_q | s1_b_q);
                    default: alu_res_d = s1_a_q | s1_b_q;
                endcase
            end
            default: alu_err_d = 1'b1;
        endcase
    end

    // A match at the handshake beats a simultaneous clear.
    always_comb begin
        irq_d = irq_q;
        cnt_d = cnt_q;
        if (good_hs && s2_res_q == IRQ_VAL) irq_d = 1'b1;
        else if (irq_clr_i)                 irq_d = 1'b0;
        if (good_hs) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_err_q   <= 1'b0;
            irq_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_mode_q <= mode_i;
                    s1_op_q   <= op_i;
                    s1_a_q    <= a_i;
                    s1_b_q    <= b_i;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q <= alu_res_d;
                    s2_err_q <= alu_err_d;
                end
            end
            irq_q <= irq_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_valid_q;
    assign result_o    = s2_res_q;
    assign out_err_o   = s2_err_q;
    assign irq_o       = irq_q;
    assign op_count_o  = cnt_q;
endmodule
